sbox_ctrl: RTL and testbench
============================

SBOX_CTRL -- requirements
Module: sbox_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, S-memory address width (256 entries).
REQ-002 Clock and reset: one clock; reset is synchronous and active-low.
REQ-003 clk  in  1  system clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 en  in  1  start request; honoured only while rdy=1.
REQ-006 rdy  out  1  high when idle and able to accept en.
REQ-007 init_en  out  1  one-cycle start pulse to the init (S[i]=i) engine.
REQ-008 init_rdy  in  1  init engine ready/done.
REQ-009 init_addr  in  ADDR_W  init engine S-memory address.
REQ-010 init_wrdata  in  8  init engine write data.
REQ-011 init_wren  in  1  init engine write enable.
REQ-012 ksa_en  out  1  one-cycle start pulse to the key-scheduling engine.
REQ-013 ksa_rdy  in  1  KSA engine ready/done.
REQ-014 ksa_addr  in  ADDR_W  KSA engine S-memory address.
REQ-015 ksa_wrdata  in  8  KSA engine write data.
REQ-016 ksa_wren  in  1  KSA engine write enable.
REQ-017 ksa_rddata  out  8  S-memory read data to KSA; equals s_rddata at all times.
REQ-018 s_addr  out  ADDR_W  shared single-port S-memory address.
REQ-019 s_wrdata  out  8  shared S-memory write data.
REQ-020 s_wren  out  1  shared S-memory write enable.
REQ-021 s_rddata  in  8  shared S-memory read data (1-cycle synchronous read).
REQ-022 conflict  out  1  sticky flag: a non-owning engine asserted its wren.

Function
REQ-023 FSM states: IDLE, INIT_GO, INIT_ACK, INIT_RUN, KSA_GO, KSA_ACK, KSA_RUN, DONE.
REQ-024 IDLE: rdy=1; en=1 moves to INIT_GO next cycle; rdy=0 in every other state.
REQ-025 INIT_GO: waits for init_rdy=1, then asserts init_en for exactly one cycle and moves to INIT_ACK.
REQ-026 INIT_ACK: waits for init_rdy=0, then moves to INIT_RUN; INIT_RUN: waits for init_rdy=1, then moves to KSA_GO.
REQ-027 KSA_GO, KSA_ACK and KSA_RUN mirror REQ-025/026 with the ksa_* signals; KSA_RUN exits to DONE on ksa_rdy=1.
REQ-028 DONE lasts one cycle, then returns to IDLE (rdy=1 the cycle after DONE).
REQ-029 Owner is INIT in INIT_*, KSA in KSA_*, NONE in IDLE/DONE; owner derives from the registered state only.
REQ-030 s_addr, s_wrdata and s_wren are a combinational mux of the owner's signals (zero-cycle latency); owner NONE drives 0/0/0.
REQ-031 A non-owner's wren never reaches s_wren; it sets conflict at the next edge, and conflict stays set until reset.
REQ-032 en asserted while rdy=0 is ignored, with no queuing.
REQ-033 An engine holding rdy=1 in its *_GO state receives the pulse immediately; en=1 held high in IDLE after DONE starts a new run.
REQ-034 init_en and ksa_en are never high together, and each is high for at most one cycle per run.

Reset
REQ-035 rst_n=0 at a clock edge forces IDLE, rdy=1, init_en=ksa_en=0, owner NONE (s_wren=0, s_addr=0, s_wrdata=0), conflict=0, from any state, including mid-run.
REQ-036 After reset release, no start pulse is issued until a new en is received.

Structure
REQ-037 Shared package sbox_pkg holds the state enum, the owner enum (NONE/INIT/KSA), ADDR_W default and S-memory depth constant 256.
REQ-038 The owner-select mux is a sub-module s_mem_mux (combinational; owner, two client buses in, memory bus out).

Verification
REQ-039 Reset, then pulse en with stub init (rdy drops 1 cycle after en, rises 256 cycles later) and stub KSA (768 cycles) -> exactly one init_en then one ksa_en; rdy returns to 1 at 1026-1030 cycles; attached bram reads back S[i]=i after init.
REQ-040 During INIT_RUN the KSA stub drives ksa_wren=1, ksa_addr=0x05 -> s_wren follows init only, S[5] remains 0x05, conflict=1 the next cycle and stays 1.
REQ-041 During KSA_RUN at address 0x10, s_rddata=0xAB -> ksa_rddata=0xAB in the same cycle; s_addr=0x10 combinationally.
REQ-042 Assert rst_n=0 for one cycle mid-KSA_RUN -> next cycle rdy=1, s_wren=0, conflict=0; a new en restarts from INIT_GO.
REQ-043 Pulse en while busy, and hold init_rdy=0 in INIT_GO for 5 cycles -> no extra start; init_en fires only on the first cycle with init_rdy=1.

Source files
------------

// File: rtl/sbox_pkg.sv
// sbox_pkg: shared types and constants for the S-box init/KSA controller
package sbox_pkg;
  localparam int S_DEPTH = 256;
  localparam int ADDR_W_DEF = $clog2(S_DEPTH);
  typedef enum logic [2:0] {IDLE, INIT_GO, INIT_ACK, INIT_RUN, KSA_GO, KSA_ACK, KSA_RUN, DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_INIT, OWN_KSA} owner_t;
  function automatic owner_t owner_of(state_t s);
    return (s inside {INIT_GO, INIT_ACK, INIT_RUN}) ? OWN_INIT :
           (s inside {KSA_GO, KSA_ACK, KSA_RUN}) ? OWN_KSA : OWN_NONE;
  endfunction
endpackage

// File: rtl/sbox_if.sv
// sbox_if: single-port S-memory bus; master drives address/data/enable, slave returns read data
interface sbox_if import sbox_pkg::*; #(parameter int ADDR_W = ADDR_W_DEF);
  logic [ADDR_W-1:0] addr;
  logic [7:0] wrdata;
  logic [7:0] rddata;
  logic wren;
  modport master (output addr, wrdata, wren, input rddata);
  modport slave (input addr, wrdata, wren, output rddata);
endinterface

// File: rtl/s_mem_mux.sv
// s_mem_mux: routes the owning engine's bus onto the shared S-memory, zeros when unowned
module s_mem_mux import sbox_pkg::*; #(parameter int ADDR_W = ADDR_W_DEF) (
  input  owner_t            owner,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [7:0]        a_wrdata,
  input  logic              a_wren,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [7:0]        b_wrdata,
  input  logic              b_wren,
  output logic [ADDR_W-1:0] s_addr,
  output logic [7:0]        s_wrdata,
  output logic              s_wren
);
  always_comb begin
    s_addr = owner == OWN_INIT ? a_addr : owner == OWN_KSA ? b_addr : '0;
    s_wrdata = owner == OWN_INIT ? a_wrdata : owner == OWN_KSA ? b_wrdata : '0;
    s_wren = owner == OWN_INIT ? a_wren : owner == OWN_KSA ? b_wren : 1'b0;
  end
endmodule

// File: rtl/sbox_ctrl.sv
// sbox_ctrl: sequences the init engine then the KSA engine and arbitrates the shared S-memory
module sbox_ctrl import sbox_pkg::*; #(parameter int ADDR_W = ADDR_W_DEF) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    en,
  output logic    rdy,
  output logic    init_en,
  input  logic    init_rdy,
  output logic    ksa_en,
  input  logic    ksa_rdy,
  sbox_if.slave   init_bus,
  sbox_if.slave   ksa_bus,
  sbox_if.master  s_bus,
  output logic    conflict
);
  state_t state;
  owner_t owner;
  assign owner = owner_of(state);
  assign init_bus.rddata = s_bus.rddata;
  assign ksa_bus.rddata = s_bus.rddata;
  s_mem_mux #(.ADDR_W(ADDR_W)) u_mux (
    .owner(owner),
    .a_addr(init_bus.addr), .a_wrdata(init_bus.wrdata), .a_wren(init_bus.wren),
    .b_addr(ksa_bus.addr), .b_wrdata(ksa_bus.wrdata), .b_wren(ksa_bus.wren),
    .s_addr(s_bus.addr), .s_wrdata(s_bus.wrdata), .s_wren(s_bus.wren)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      rdy <= 1'b1;
      init_en <= 1'b0;
      ksa_en <= 1'b0;
      conflict <= 1'b0;
    end else begin
      init_en <= 1'b0;
      ksa_en <= 1'b0;
      if ((owner != OWN_INIT && init_bus.wren) || (owner != OWN_KSA && ksa_bus.wren)) conflict <= 1'b1;
      case (state)
        IDLE: if (en) begin state <= INIT_GO; rdy <= 1'b0; end
        INIT_GO: if (init_rdy) begin state <= INIT_ACK; init_en <= 1'b1; end
        INIT_ACK: if (!init_rdy) state <= INIT_RUN;
        INIT_RUN: if (init_rdy) state <= KSA_GO;
        KSA_GO: if (ksa_rdy) begin state <= KSA_ACK; ksa_en <= 1'b1; end
        KSA_ACK: if (!ksa_rdy) state <= KSA_RUN;
        KSA_RUN: if (ksa_rdy) state <= DONE;
        DONE: begin state <= IDLE; rdy <= 1'b1; end
        default: begin state <= IDLE; rdy <= 1'b1; end
      endcase
    end
  end
endmodule

// File: tb/tb_sbox_ctrl.sv
// tb_sbox_ctrl: directed run of sbox_ctrl with stub engines driven inline and a small S-memory model
module tb_sbox_ctrl;
  import sbox_pkg::*;
  logic clk = 0, rst_n = 0, en = 0, init_rdy = 1, ksa_rdy = 1;
  logic rdy, init_en, ksa_en, conflict;
  sbox_if init_bus();
  sbox_if ksa_bus();
  sbox_if s_bus();
  sbox_ctrl dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .init_en(init_en), .init_rdy(init_rdy),
    .ksa_en(ksa_en), .ksa_rdy(ksa_rdy), .init_bus(init_bus), .ksa_bus(ksa_bus),
    .s_bus(s_bus), .conflict(conflict)
  );
  always #5 clk = ~clk;
  logic [7:0] mem [256];
  logic [7:0] q, fv;
  logic frc = 0;
  always @(posedge clk) begin
    if (s_bus.wren) mem[s_bus.addr] <= s_bus.wrdata;
    q <= mem[s_bus.addr];
  end
  assign s_bus.rddata = frc ? fv : q;
  int n_cmp = 0, n_bad = 0, n_init = 0, n_ksa = 0, both = 0, cyc = 0, t0 = 0;
  always @(negedge clk) begin
    if (init_en) n_init++;
    if (ksa_en) n_ksa++;
    if (init_en && ksa_en) both++;
  end
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, o, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  logic [7:0] ra [4];
  initial begin
    ra[0] = 8'h00; ra[1] = 8'h05; ra[2] = 8'h0A; ra[3] = 8'hFF;
    fv = 8'h00;
    init_bus.addr = '0; init_bus.wrdata = '0; init_bus.wren = 0;
    ksa_bus.addr = '0; ksa_bus.wrdata = '0; ksa_bus.wren = 0;
    tick(); tick();
    chk("rst_rdy", rdy, 1);
    chk("rst_init_en", init_en, 0);
    chk("rst_ksa_en", ksa_en, 0);
    chk("rst_s_wren", s_bus.wren, 0);
    chk("rst_s_addr", s_bus.addr, 0);
    chk("rst_s_wrdata", s_bus.wrdata, 0);
    chk("rst_conflict", conflict, 0);
    rst_n = 1;
    tick(); tick();
    chk("no_start_after_rst", n_init, 0);
    // run 1: full init + KSA with a conflicting KSA write during init
    en = 1;
    tick();
    t0 = cyc;
    en = 0;
    chk("busy_rdy", rdy, 0);
    tick();
    chk("init_pulse", init_en, 1);
    chk("init_pulse_no_ksa", ksa_en, 0);
    init_rdy = 0;
    for (int k = 0; k < 256; k++) begin
      init_bus.addr = k[7:0]; init_bus.wrdata = k[7:0]; init_bus.wren = 1;
      if (k == 10) begin
        ksa_bus.wren = 1; ksa_bus.addr = 8'h05; ksa_bus.wrdata = 8'hEE;
        #1;
        chk("conf_s_wren", s_bus.wren, 1);
        chk("conf_s_addr", s_bus.addr, 8'h0A);
        chk("conf_s_wrdata", s_bus.wrdata, 8'h0A);
      end
      tick();
      if (k == 0) chk("init_pulse_once", init_en, 0);
      if (k == 10) begin
        ksa_bus.wren = 0;
        chk("conflict_set", conflict, 1);
      end
    end
    init_bus.wren = 0;
    init_rdy = 1;
    tick();
    chk("ksa_go_no_pulse", ksa_en, 0);
    tick();
    chk("ksa_pulse", ksa_en, 1);
    chk("ksa_pulse_no_init", init_en, 0);
    ksa_rdy = 0;
    for (int j = 0; j < 768; j++) begin
      if (j < 4) ksa_bus.addr = ra[j];
      if (j == 10) begin
        ksa_bus.addr = 8'h10; fv = 8'hAB; frc = 1;
        #1;
        chk("rd_s_addr", s_bus.addr, 8'h10);
        chk("rd_passthru", ksa_bus.rddata, 8'hAB);
        frc = 0;
      end
      if (j == 20) begin
        ksa_bus.addr = 8'h20; ksa_bus.wrdata = 8'h77; ksa_bus.wren = 1;
        #1;
        chk("ksa_s_wren", s_bus.wren, 1);
        chk("ksa_s_wrdata", s_bus.wrdata, 8'h77);
      end
      tick();
      ksa_bus.wren = 0;
      if (j < 4) chk($sformatf("bram_S%0h", ra[j]), ksa_bus.rddata, ra[j]);
    end
    ksa_rdy = 1;
    tick();
    chk("done_rdy", rdy, 0);
    tick();
    chk("idle_rdy", rdy, 1);
    chk("run_latency", cyc - t0, 1029);
    chk("run1_init_pulses", n_init, 1);
    chk("run1_ksa_pulses", n_ksa, 1);
    chk("conflict_sticky", conflict, 1);
    // run 2: reset in the middle of KSA_RUN
    en = 1;
    tick();
    en = 0;
    tick();
    init_rdy = 0;
    tick();
    init_rdy = 1;
    tick();
    tick();
    ksa_rdy = 0;
    tick();
    ksa_bus.wren = 1; ksa_bus.addr = 8'h33;
    #1;
    chk("midrun_s_wren", s_bus.wren, 1);
    rst_n = 0;
    tick();
    chk("midrst_rdy", rdy, 1);
    chk("midrst_s_wren", s_bus.wren, 0);
    chk("midrst_s_addr", s_bus.addr, 0);
    chk("midrst_conflict", conflict, 0);
    ksa_bus.wren = 0;
    rst_n = 1;
    ksa_rdy = 1;
    // run 3: start stalls in INIT_GO, en while busy, en held across DONE
    init_rdy = 0;
    en = 1;
    tick();
    chk("r3_busy", rdy, 0);
    for (int h = 0; h < 5; h++) begin
      if (h == 2) en = 0;
      tick();
      chk("stall_no_pulse", init_en, 0);
    end
    init_rdy = 1;
    tick();
    chk("stall_pulse", init_en, 1);
    init_rdy = 0;
    tick();
    init_rdy = 1;
    tick();
    tick();
    ksa_rdy = 0;
    tick();
    ksa_rdy = 1;
    tick();
    en = 1;
    tick();
    chk("r3_idle_rdy", rdy, 1);
    tick();
    chk("held_en_restart", rdy, 0);
    chk("total_init_pulses", n_init, 3);
    chk("total_ksa_pulses", n_ksa, 3);
    chk("never_both", both, 0);
    en = 0;
    rst_n = 0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
